// File: rtl/onehot_pkg.sv
// Shared helpers for the one-hot state monitor: reset code and the
// one-hot legality / binary-encode functions. Vectors are handled at
// MAX_STATES width and callers zero-extend into them.
package onehot_pkg;

    localparam int MAX_STATES = 64;
    localparam int MAX_IDX_W  = 6;

    // Reset code of the monitored FSM: LSB set.
    localparam logic [MAX_STATES-1:0] ST_RST = 'h01;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot(input logic [MAX_STATES-1:0] vec);
        return (vec != '0) && ((vec & (vec - MAX_STATES'(1))) == '0);
    endfunction

    // OR-reduction encoder. It is exact for legal one-hot input and harmless otherwise,
    // because callers only use the result when is_onehot() holds.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_bin(input logic [MAX_STATES-1:0] vec);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_STATES; i++) begin
            if (vec[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot to binary encoder with a legality flag.
// NUM_STATES must not exceed onehot_pkg::MAX_STATES.
module onehot_enc
    import onehot_pkg::*;
#(
    parameter int NUM_STATES = 3
) (
    input  logic [NUM_STATES-1:0]         vec,
    output logic [$clog2(NUM_STATES)-1:0] bin,
    output logic                          legal
);

    localparam int IDX_W = $clog2(NUM_STATES);

    logic [MAX_STATES-1:0] vec_ext;

    assign vec_ext = MAX_STATES'(vec);
    assign legal   = is_onehot(vec_ext);
    assign bin     = IDX_W'(onehot_to_bin(vec_ext));

endmodule

// File: rtl/onehot_state_monitor.sv
// Passive observer of a one-hot FSM state register. It samples the
// vector, encodes it, flags illegal codes, pulses on transitions and
// counts a saturating dwell time.
// Optional trace buffer: define ONEHOT_MON_TRACE_EN to add
// trace_idx/trace_state and a 4-deep history of legal states entered.
module onehot_state_monitor
    import onehot_pkg::*;
#(
    parameter int NUM_STATES = 3,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 200
) (
    input  logic                          clk,
    input  logic                          CLRN,
    input  logic [NUM_STATES-1:0]         state,
    input  logic                          clr_err,
`ifdef ONEHOT_MON_TRACE_EN
    input  logic [1:0]                    trace_idx,
    output logic [$clog2(NUM_STATES)-1:0] trace_state,
`endif
    output logic [$clog2(NUM_STATES)-1:0] enc_state,
    output logic                          enc_vld,
    output logic                          trans,
    output logic [CNT_W-1:0]              dwell_cnt,
    output logic                          illegal,
    output logic                          err_sticky,
    output logic                          timeout
);

    localparam int                    IDX_W   = $clog2(NUM_STATES);
    localparam logic [NUM_STATES-1:0] RST_VEC = ST_RST[NUM_STATES-1:0];
    localparam logic [CNT_W-1:0]      CNT_MAX = '1;
    localparam logic [CNT_W-1:0]      TO_VAL  = CNT_W'(TIMEOUT);

    logic [NUM_STATES-1:0] st_q;
    logic [NUM_STATES-1:0] st_prv;
    logic [IDX_W-1:0]      enc_bin;
    logic [IDX_W-1:0]      enc_last;
    logic                  enc_legal;

    onehot_enc #(.NUM_STATES(NUM_STATES)) u_enc (
        .vec   (st_q),
        .bin   (enc_bin),
        .legal (enc_legal)
    );

    // Two-deep sample pipeline. Reset loads the FSM reset code into both
    // stages, so no transition is seen right after reset.
    always_ff @(posedge clk or negedge CLRN) begin
        if (!CLRN) begin
            st_q   <= RST_VEC;
            st_prv <= RST_VEC;
        end else begin
            st_q   <= state;
            st_prv <= st_q;
        end
    end

    // Remember the last legal index so enc_state stays meaningful across illegal codes.
    always_ff @(posedge clk or negedge CLRN) begin
        if (!CLRN)          enc_last <= '0;
        else if (enc_legal) enc_last <= enc_bin;
    end

    // Dwell counter restarts on any raw-vector change and saturates at all-ones.
    always_ff @(posedge clk or negedge CLRN) begin
        if (!CLRN)                    dwell_cnt <= '0;
        else if (trans)               dwell_cnt <= '0;
        else if (dwell_cnt != CNT_MAX) dwell_cnt <= dwell_cnt + CNT_W'(1);
    end

    // Sticky error: setting wins over clearing when both occur in the same cycle.
    always_ff @(posedge clk or negedge CLRN) begin
        if (!CLRN)        err_sticky <= 1'b0;
        else if (illegal) err_sticky <= 1'b1;
        else if (clr_err) err_sticky <= 1'b0;
    end

    assign illegal   = ~enc_legal;
    assign enc_vld   = enc_legal;
    assign enc_state = enc_legal ? enc_bin : enc_last;
    assign trans     = (st_q != st_prv);
    assign timeout   = enc_legal & (dwell_cnt >= TO_VAL);

`ifdef ONEHOT_MON_TRACE_EN
    logic [3:0][IDX_W-1:0] trace_buf;

    // Shift in each newly entered legal state. Entry 0 holds the newest one.
    always_ff @(posedge clk or negedge CLRN) begin
        if (!CLRN)                  trace_buf <= '0;
        else if (trans && enc_legal) trace_buf <= {trace_buf[2:0], enc_bin};
    end

    assign trace_state = trace_buf[trace_idx];
`endif

endmodule
